// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: streams sequential words ahead of the core PC into an in-order FIFO.
// Define PF_BYPASS_EN to forward a live response straight to a core waiting on an empty FIFO.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_core_rd_en,
    input  logic [31:0] i_core_addr,
    output logic        o_core_ready,
    output logic [31:0] o_core_data,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop;
    logic [31:0]   head_addr;
    logic [31:0]   fetch_addr;
    logic [31:0]   last_data;

    logic addr_match;
    logic redirect;
    logic hit;
    logic bypass;
    logic resp;
    logic resp_live;
    logic push;
    logic credit;
    logic grant;

    // Hit/redirect decode, issue credit and the zero-latency core response path
    always_comb begin
        addr_match = (i_core_addr == head_addr);
        redirect   = (state == STREAM) && i_core_rd_en && !addr_match;
        hit        = (state == STREAM) && i_core_rd_en && addr_match && (count != '0);
        // Responses with nothing outstanding (e.g. after reset) are ignored
        resp       = i_mem_rvalid && (outstanding != '0);
        resp_live  = resp && (drop == '0) && !redirect;
`ifdef PF_BYPASS_EN
        bypass     = (state == STREAM) && i_core_rd_en && addr_match && (count == '0) && resp_live;
`else
        bypass     = 1'b0;
`endif
        push       = resp_live && !bypass;
        credit     = ((32'(count) + 32'(outstanding) - 32'(drop)) < DEPTH)
                     && (32'(outstanding) < MAX_OUTSTANDING);
        o_mem_req  = (state == STREAM) && !redirect && credit;
        o_mem_addr = fetch_addr;
        grant      = o_mem_req && i_mem_gnt;

        o_core_ready = hit || bypass;
        o_core_data  = last_data;
        if (hit) begin
            o_core_data = fifo_mem[rd_ptr];
        end else if (bypass) begin
            o_core_data = i_mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_core_rd_en) state_next = STREAM;
            STREAM:  state_next = STREAM;
            default: state_next = IDLE;
        endcase
    end

    // Pointer, address and credit bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            head_addr   <= '0;
            fetch_addr  <= '0;
            last_data   <= '0;
        end else begin
            last_data <= o_core_data;
            if (state == IDLE) begin
                if (i_core_rd_en) begin
                    head_addr  <= i_core_addr;
                    fetch_addr <= i_core_addr;
                end
            end else if (redirect) begin
                // Everything still in flight belongs to the abandoned stream
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                drop        <= outstanding - OW'(resp);
                outstanding <= outstanding - OW'(resp);
                head_addr   <= i_core_addr;
                fetch_addr  <= i_core_addr;
            end else begin
                if (grant) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (hit) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (hit || bypass) begin
                    head_addr <= head_addr + 32'd4;
                end
                if (push && !hit) begin
                    count <= count + CW'(1);
                end else if (hit && !push) begin
                    count <= count - CW'(1);
                end
                if (grant && !resp) begin
                    outstanding <= outstanding + OW'(1);
                end else if (resp && !grant) begin
                    outstanding <= outstanding - OW'(1);
                end
                if (resp && (drop != '0)) begin
                    drop <= drop - OW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= i_mem_rdata;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !hit && (count == CW'(DEPTH))));

endmodule
